pwm_fader_array: RTL and testbench

PWM_FADER_ARRAY -- requirements
Module: pwm_fader_array

---
 rtl/pwm_fader_array.sv | 121 ++++++++++++
 tb/tb_pwm_fader_array.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fader_array.sv
// pwm_fader_array: multi-channel PWM colour fader with a shared counter, hue wheel and period-aligned config updates
module pwm_fader_array #(
  parameter int NUM_CH        = 3,
  parameter int WIDTH         = 10,
  parameter int SEG_BITS      = 6,
  parameter int DEFAULT_DELAY = 33333
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [WIDTH-1:0]  cfg_level,
  input  logic [WIDTH:0]    cfg_bright,
  input  logic [23:0]       cfg_delay,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);
  localparam int STEPS = 6 << SEG_BITS;
  localparam int SPACE = STEPS / NUM_CH;
  localparam int PW    = SEG_BITS + 3;
  localparam int SH    = WIDTH - SEG_BITS;
  localparam logic [0:0] IDLE = 1'b0, PENDING = 1'b1;
  localparam logic [1:0] M_HUE = 2'd0, M_STATIC = 2'd1, M_OFF = 2'd2;
  localparam logic [WIDTH:0]   FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] MAXV = '1;
  logic [0:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [23:0]      step;
  logic [PW-1:0]    pos;
  logic [1:0]       a_mode, s_mode, n_mode;
  logic [WIDTH-1:0] a_level, s_level, n_level;
  logic [WIDTH:0]   a_bright, s_bright, n_bright;
  logic [23:0]      a_delay, s_delay, d_eff;
  logic [WIDTH-1:0] duty [NUM_CH];
  logic [WIDTH-1:0] duty_q [NUM_CH];
  logic             wrap, apply, accept, step_tc;
  assign wrap     = cnt == MAXV;
  assign apply    = state == PENDING && wrap;
  assign accept   = cfg_valid && cfg_ready;
  // the duty latched at an applying boundary already uses the new config
  assign n_mode   = apply ? s_mode : a_mode;
  assign n_level  = apply ? s_level : a_level;
  assign n_bright = apply ? s_bright : a_bright;
  assign d_eff    = a_delay == 24'd0 ? 24'd1 : a_delay;
  assign step_tc  = step >= d_eff - 24'd1;
  for (genvar g = 0; g < NUM_CH; g++) begin : ch
    logic [PW:0]        ps;
    logic [PW-1:0]      p;
    logic [2:0]         s;
    logic [SEG_BITS-1:0] f;
    logic [WIDTH-1:0]   ramp, hue, lvl;
    logic [2*WIDTH-1:0] prod;
    assign ps   = {1'b0, pos} + (PW+1)'(g * SPACE);
    assign p    = ps >= (PW+1)'(STEPS) ? PW'(ps - (PW+1)'(STEPS)) : ps[PW-1:0];
    assign s    = p[PW-1:SEG_BITS];
    assign f    = p[SEG_BITS-1:0];
    assign ramp = WIDTH'(f) << SH;
    assign hue  = s == 3'd0 ? ramp : s <= 3'd2 ? MAXV : s == 3'd3 ? MAXV - ramp : '0;
    assign lvl  = n_mode == M_OFF ? '0 : n_mode == M_STATIC ? n_level : hue;
    assign prod = (2*WIDTH)'(lvl) * (2*WIDTH)'(n_bright);
    assign duty[g] = WIDTH'(prod >> WIDTH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_ready <= 1'b0;
      s_mode    <= M_HUE;
      s_level   <= '0;
      s_bright  <= FULL;
      s_delay   <= 24'(DEFAULT_DELAY);
    end else begin
      if (accept) begin
        state    <= PENDING;
        s_mode   <= cfg_mode;
        s_level  <= cfg_level;
        s_bright <= cfg_bright > FULL ? FULL : cfg_bright;
        s_delay  <= cfg_delay;
      end else if (apply) begin
        state <= IDLE;
      end
      cfg_ready <= accept ? 1'b0 : (state == IDLE || apply);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mode   <= M_HUE;
      a_level  <= '0;
      a_bright <= FULL;
      a_delay  <= 24'(DEFAULT_DELAY);
    end else if (apply) begin
      a_mode   <= s_mode;
      a_level  <= s_level;
      a_bright <= s_bright;
      a_delay  <= s_delay;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      step <= '0;
      pos  <= '0;
    end else begin
      cnt  <= cnt + WIDTH'(1);
      step <= (apply || step_tc) ? 24'd0 : step + 24'd1;
      if (!apply && step_tc && a_mode == M_HUE)
        pos <= pos == PW'(STEPS - 1) ? '0 : pos + PW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) duty_q[k] <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      for (int k = 0; k < NUM_CH; k++) pwm_out[k] <= cnt < duty_q[k];
      if (wrap) duty_q <= duty;
    end
  end
endmodule

// File: tb/tb_pwm_fader_array.sv
// tb_pwm_fader_array: randomized and directed checks of pwm_fader_array against a cycle-level behavioural model
module tb_pwm_fader_array;
  localparam int N = 3, W = 4, SB = 2, DD = 5;
  logic clk = 0, rst_n = 0, cfg_valid = 0;
  logic [1:0]   cfg_mode = 0;
  logic [W-1:0] cfg_level = 0;
  logic [W:0]   cfg_bright = 0;
  logic [23:0]  cfg_delay = 0;
  logic         cfg_ready, period_tick;
  logic [N-1:0] pwm_out;
  int n_chk = 0, n_err = 0;
  int m_cnt, m_step, m_pos, m_duty [3];
  bit [2:0] m_pwm;
  bit m_tick, m_rdy, m_pend;
  int a_mode, a_lvl, a_br, a_dly, s_mode, s_lvl, s_br, s_dly;
  int nm, nl, nb, d;
  bit bnd, app, acc;
  int hi [3];
  int hp, ex [3];

  pwm_fader_array #(.NUM_CH(N), .WIDTH(W), .SEG_BITS(SB), .DEFAULT_DELAY(DD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_level(cfg_level), .cfg_bright(cfg_bright),
    .cfg_delay(cfg_delay), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hue_of(int p);
    int s, f;
    s = p / 4;
    f = p % 4;
    return s == 0 ? f * 4 : s < 3 ? 15 : s == 3 ? 15 - f * 4 : 0;
  endfunction

  function automatic int duty_of(int mode, int lvl, int br, int p);
    int l;
    l = mode == 2 ? 0 : mode == 1 ? lvl : hue_of(p);
    return (l * br) / 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_step = 0; m_pos = 0; m_pwm = 0; m_tick = 0; m_rdy = 0; m_pend = 0;
      for (int k = 0; k < 3; k++) m_duty[k] = 0;
      a_mode = 0; a_lvl = 0; a_br = 16; a_dly = DD;
    end else begin
      bnd = m_cnt == 15;
      app = m_pend && bnd;
      acc = cfg_valid && m_rdy;
      nm = app ? s_mode : a_mode;
      nl = app ? s_lvl : a_lvl;
      nb = app ? s_br : a_br;
      for (int k = 0; k < 3; k++) m_pwm[k] = m_cnt < m_duty[k];
      if (bnd) for (int k = 0; k < 3; k++) m_duty[k] = duty_of(nm, nl, nb, (m_pos + k * 8) % 24);
      m_tick = bnd;
      d = a_dly == 0 ? 1 : a_dly;
      if (app) m_step = 0;
      else if (m_step + 1 >= d) begin
        m_step = 0;
        if (a_mode == 0) m_pos = (m_pos + 1) % 24;
      end else m_step++;
      if (app) begin
        a_mode = s_mode; a_lvl = s_lvl; a_br = s_br; a_dly = s_dly; m_pend = 0;
      end
      if (acc) begin
        s_mode = int'(cfg_mode); s_lvl = int'(cfg_level);
        s_br = cfg_bright > 16 ? 16 : int'(cfg_bright);
        s_dly = int'(cfg_delay); m_pend = 1;
      end
      m_rdy = !m_pend;
      m_cnt = (m_cnt + 1) % 16;
    end
  end

  always @(negedge clk) if (rst_n) begin
    check("pwm", pwm_out, m_pwm);
    check("tick", period_tick, m_tick);
    check("ready", cfg_ready, m_rdy);
  end

  task automatic drive(int mode, int lvl, int br, int dly);
    cfg_mode = 2'(mode); cfg_level = W'(lvl); cfg_bright = (W+1)'(br); cfg_delay = 24'(dly);
  endtask

  task automatic wait_cnt(int v);
    int t;
    @(negedge clk);
    for (t = 0; t < 40 && m_cnt != v; t++) @(negedge clk);
    if (m_cnt != v) check("wait_cnt", m_cnt, v);
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 40 && !cfg_ready; t++) @(negedge clk);
    check("idle_wait", cfg_ready, 1);
  endtask

  task automatic send_cfg(int mode, int lvl, int br, int dly);
    int t;
    @(negedge clk);
    drive(mode, lvl, br, dly);
    cfg_valid = 1;
    for (t = 0; t < 40 && !cfg_ready; t++) @(negedge clk);
    check("accept_wait", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic measure();
    wait_cnt(15);
    hp = m_pos;
    @(negedge clk);
    hi = '{default: 0};
    repeat (16) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) hi[k] += int'(pwm_out[k]);
    end
  endtask

  task automatic chk3(input string tag, int e0, int e1, int e2);
    check({tag, "_ch0"}, hi[0], e0);
    check({tag, "_ch1"}, hi[1], e1);
    check({tag, "_ch2"}, hi[2], e2);
  endtask

  task automatic reset_release();
    int n;
    rst_n = 1;
    @(negedge clk);
    check("ready_after_rst", cfg_ready, 1);
    n = 1;
    while (!period_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("first_tick", n, 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen0, seen23;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_tick", period_tick, 0);
    reset_release();
    repeat (100) @(negedge clk);
    send_cfg(1, 5, 16, 7); wait_idle();
    repeat (2) begin measure(); chk3("static5", 5, 5, 5); end
    send_cfg(1, 12, 8, 7); wait_idle(); measure(); chk3("bright8", 6, 6, 6);
    send_cfg(1, 12, 31, 7); wait_idle(); measure(); chk3("bright_sat", 12, 12, 12);
    wait_cnt(3);
    drive(1, 3, 16, 1);
    cfg_valid = 1;
    @(negedge clk);
    check("ready_drop", cfg_ready, 0);
    drive(1, 9, 16, 1);
    n = 0;
    while (!cfg_ready && n < 40) begin n++; @(negedge clk); end
    check("holdoff", n, 12);
    @(negedge clk);
    cfg_valid = 0;
    wait_idle(); measure(); chk3("second_cfg", 9, 9, 9);
    wait_cnt(15);
    drive(1, 7, 16, 1);
    cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
    n = 0;
    while (!cfg_ready && n < 40) begin n++; @(negedge clk); end
    check("late_accept", n, 16);
    measure(); chk3("late_cfg", 7, 7, 7);
    send_cfg(0, 0, 16, 17); wait_idle();
    seen0 = 0; seen23 = 0;
    for (int r = 0; r < 60; r++) begin
      measure();
      if (hp == 0) begin seen0 = 1; chk3("hue_pos0", 0, 15, 0); end
      if (hp == 23) begin seen23 = 1; chk3("hue_pos23", 0, 15, 3); end
    end
    check("seen_pos0", seen0, 1);
    check("seen_pos23", seen23, 1);
    send_cfg(0, 0, 16, 1); wait_idle();
    repeat (37) @(negedge clk);
    send_cfg(2, 0, 16, 1); wait_idle();
    repeat (3) begin measure(); chk3("off", 0, 0, 0); end
    send_cfg(3, 0, 16, 1); wait_idle();
    for (int k = 0; k < 3; k++) ex[k] = hue_of((m_pos + k * 8) % 24);
    repeat (100) begin measure(); chk3("freeze", ex[0], ex[1], ex[2]); end
    send_cfg(0, 0, 16, 1); wait_idle();
    repeat (60) @(negedge clk);
    for (int r = 0; r < 60; r++) begin
      send_cfg($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 3));
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    send_cfg(1, 12, 16, 1); wait_idle();
    wait_cnt(1);
    drive(2, 0, 16, 1);
    cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
    check("pre_rst_pwm", pwm_out, 3'b111);
    #3 rst_n = 0;
    #1;
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_ready", cfg_ready, 0);
    check("async_rst_tick", period_tick, 0);
    repeat (2) @(negedge clk);
    check("held_rst_pwm", pwm_out, 0);
    reset_release();
    repeat (120) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
